clk_fanout_ctrl: RTL and testbench

CLK_FANOUT_CTRL -- requirements
Module: clk_fanout_ctrl

---
 rtl/clk_fanout_ctrl.sv | 146 ++++++++++++++
 tb/tb_clk_fanout_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_fanout_ctrl.sv
// Forwarded-clock fan-out controller: divides clk into CH gated clocks once the DCM lock is stable.
// Latency: clk_o is registered, one cycle behind the internal phase bit.
// Start, stop, divider and enable changes only take effect at a period boundary, so no pulse is ever shortened.
module clk_fanout_ctrl #(
  parameter int CH        = 4,
  parameter int DIV_W     = 8,
  parameter int LOCK_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load,
  input  logic [CH-1:0]    en_i,
  output logic [CH-1:0]    clk_o,
  output logic [CH-1:0]    active_o,
  output logic             ready_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  localparam int WC_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(LOCK_WAIT - 1);

  logic [1:0]       sync_q;
  logic             locked_s;
  logic [1:0]       state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ph_q, ph_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic [CH-1:0]    active_q, active_d;
  logic [CH-1:0]    clk_q;

  logic [DIV_W-1:0] half_m1;
  logic             cnt_wrap;
  logic             running;
  logic             bnd;
  logic             go_run;

  assign locked_s = sync_q[1];
  // A divider of 0 behaves like 1, so the last count of a half period is 0 in both cases.
  assign half_m1  = (div_act_q == '0) ? '0 : div_act_q - DIV_W'(1);
  assign cnt_wrap = (cnt_q == half_m1);
  assign running  = (state_q == S_RUN) || (state_q == S_STOP);
  assign bnd      = running && ph_q && cnt_wrap;
  assign go_run   = (state_q == S_WAIT) && locked_s && (wcnt_q == WC_LAST);

  // Two-flop synchroniser for the asynchronous lock status.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], locked_i};
  end

  // Next-state logic: FSM, lock-stability counter, divider, pending divider and channel enables.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    cnt_d      = '0;
    ph_d       = 1'b0;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    active_d   = active_q;

    case (state_q)
      S_IDLE: begin
        wcnt_d = '0;
        if (locked_s) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!locked_s) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else if (go_run) begin
          state_d  = S_RUN;
          wcnt_d   = '0;
          active_d = en_i;
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end
      S_RUN: begin
        if (!locked_s) state_d = S_STOP;
      end
      default: begin
        if (bnd) state_d = S_IDLE;
      end
    endcase

    // Shared half-period counter; frozen at zero outside RUN/STOP so every start begins with a full low phase.
    if (running) begin
      if (cnt_wrap) begin
        cnt_d = '0;
        ph_d  = ~ph_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
        ph_d  = ph_q;
      end
    end

    // Boundary updates: the pending divider takes over and enables are re-sampled (or cleared when stopping).
    if (bnd) begin
      div_act_d = div_pend_q;
      active_d  = (state_q == S_RUN) ? en_i : '0;
    end

    // While idle the divider applies at once; div_pend tracks it so the next boundary keeps the same value.
    // A load coinciding with a boundary only becomes pending; the old pending value is applied above.
    if (div_load) begin
      div_pend_d = div_i;
      if (!running) div_act_d = div_i;
    end
  end

  // State registers with synchronous reset; reset is the only event allowed to cut a pulse short.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      cnt_q      <= '0;
      ph_q       <= 1'b0;
      div_act_q  <= DIV_W'(1);
      div_pend_q <= DIV_W'(1);
      active_q   <= '0;
      clk_q      <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      active_q   <= active_d;
      clk_q      <= {CH{ph_q}} & active_q;
    end
  end

  assign clk_o    = clk_q;
  assign active_o = active_q;
  assign ready_o  = (state_q == S_RUN);

endmodule

// File: tb/tb_clk_fanout_ctrl.sv
// Randomised bench for clk_fanout_ctrl against a period-position reference model.
// Model advances once per rising edge; DUT outputs are compared on the falling edge.
// Directed phases cover startup, divide/enable, mid-period enable, divider change, lock loss and reset.
module tb_clk_fanout_ctrl;

  localparam int CH = 4;
  localparam int DW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          locked_i;
  logic [DW-1:0] div_i;
  logic          div_load;
  logic [CH-1:0] en_i;
  logic [CH-1:0] clk_o;
  logic [CH-1:0] active_o;
  logic          ready_o;

  int n_chk = 0;
  int n_err = 0;

  clk_fanout_ctrl #(.CH(CH), .DIV_W(DW), .LOCK_WAIT(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .locked_i (locked_i),
    .div_i    (div_i),
    .div_load (div_load),
    .en_i     (en_i),
    .clk_o    (clk_o),
    .active_o (active_o),
    .ready_o  (ready_o)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 waiting for lock, 2 running, 3 stopping.
  // pos is the position within the current period (0..2H-1), high half is pos >= H.
  bit            m_l0, m_l1;
  int            m_mode, m_stable, m_pos, m_div, m_pend;
  logic [CH-1:0] m_act, m_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int            h, pos_n, div_n, pend_n, mode_n, stable_n;
    bit            run, bnd, ls;
    logic [CH-1:0] act_n, clk_n;
    if (rst) begin
      m_l0 = 0; m_l1 = 0; m_mode = 0; m_stable = 0; m_pos = 0;
      m_div = 1; m_pend = 1; m_act = '0; m_clk = '0;
      return;
    end
    ls       = m_l1;
    h        = (m_div == 0) ? 1 : m_div;
    run      = (m_mode >= 2);
    bnd      = run && (m_pos == 2 * h - 1);
    clk_n    = (run && m_pos >= h) ? m_act : '0;
    pos_n    = (run && !bnd) ? m_pos + 1 : 0;
    div_n    = bnd ? m_pend : m_div;
    pend_n   = m_pend;
    act_n    = m_act;
    mode_n   = m_mode;
    stable_n = m_stable;
    if (div_load) begin
      pend_n = int'(div_i);
      if (!run) div_n = int'(div_i);
    end
    if (bnd) act_n = (m_mode == 2) ? en_i : '0;
    case (m_mode)
      0: begin stable_n = 0; if (ls) mode_n = 1; end
      1: begin
        if (!ls) begin mode_n = 0; stable_n = 0; end
        else begin
          stable_n = m_stable + 1;
          if (stable_n == LW) begin mode_n = 2; stable_n = 0; act_n = en_i; end
        end
      end
      2: if (!ls) mode_n = 3;
      default: if (bnd) mode_n = 0;
    endcase
    m_l1 = m_l0; m_l0 = locked_i;
    m_mode = mode_n; m_stable = stable_n; m_pos = pos_n;
    m_div = div_n; m_pend = pend_n; m_act = act_n; m_clk = clk_n;
  endtask

  // One clock: DUT and model consume the same inputs, then outputs are compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("clk_o", 32'(clk_o), 32'(m_clk));
    chk("active_o", 32'(active_o), 32'(m_act));
    chk("ready_o", 32'(ready_o), 32'(m_mode == 2));
    div_load = 1'b0;
  endtask

  // Edges from raising locked_i until ready_o is seen high (-1 if it never comes).
  task automatic startup(output int edges);
    locked_i = 1'b1;
    edges = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (ready_o) begin edges = i; break; end
    end
  endtask

  // Length of the next complete high pulse on channel ch (-1 on timeout).
  task automatic measure_high(input int ch, output int len);
    int i;
    len = -1;
    i = 0;
    while (clk_o[ch] !== 1'b0 && i < 200) begin tick(); i++; end
    while (clk_o[ch] !== 1'b1 && i < 200) begin tick(); i++; end
    if (i >= 200) return;
    len = 0;
    while (clk_o[ch] === 1'b1 && len < 200) begin tick(); len++; end
  endtask

  initial begin
    int e, len;
    bit seen;
    rst = 1'b1; locked_i = 1'b0; div_i = '0; div_load = 1'b0; en_i = '0;
    tick(); tick();
    chk("rst_clk", 32'(clk_o), 32'h0);
    chk("rst_active", 32'(active_o), 32'h0);
    chk("rst_ready", 32'(ready_o), 32'h0);
    rst = 1'b0;
    tick();

    // Divider 2 loaded while idle, channels 0 and 2 enabled, then lock.
    div_i = 8'd2; div_load = 1'b1; en_i = 4'b0101;
    tick();
    startup(e);
    chk("startup_edges", 32'(e), 32'(LW + 3));
    chk("active_0101", 32'(active_o), 32'h5);
    measure_high(0, len);
    chk("high_div2", 32'(len), 32'd2);
    repeat (12) tick();

    // Enable moves from channel 0 to channel 1 in the middle of a high phase.
    en_i = 4'b0001;
    measure_high(0, len);
    e = 0;
    while (clk_o[0] !== 1'b1 && e < 50) begin tick(); e++; end
    en_i = 4'b0010;
    repeat (16) tick();
    chk("en_moved", 32'(active_o), 32'h2);

    // Divider change while running, then zero as the smallest divider.
    div_i = 8'd3; div_load = 1'b1;
    tick();
    repeat (8) tick();
    measure_high(1, len);
    chk("high_div3", 32'(len), 32'd3);
    div_i = 8'd0; div_load = 1'b1;
    tick();
    repeat (10) tick();
    measure_high(1, len);
    chk("high_div0", 32'(len), 32'd1);

    // Lock loss while running: ready drops after three edges, channels stop at the boundary.
    div_i = 8'd2; div_load = 1'b1; en_i = 4'hF;
    tick();
    repeat (9) tick();
    locked_i = 1'b0;
    e = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (!ready_o) begin e = i; break; end
    end
    chk("lockloss_edges", 32'(e), 32'd3);
    repeat (20) tick();
    chk("stopped_active", 32'(active_o), 32'h0);
    chk("stopped_clk", 32'(clk_o), 32'h0);

    // Short lock glitch while waiting must not produce any pulse.
    locked_i = 1'b1;
    repeat (8) tick();
    locked_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin tick(); if (clk_o != '0 || ready_o) seen = 1'b1; end
    chk("wait_glitch", 32'(seen), 32'd0);

    // Reset in the middle of a high pulse, then the startup sequence repeats.
    startup(e);
    e = 0;
    while (clk_o == '0 && e < 50) begin tick(); e++; end
    rst = 1'b1;
    tick();
    chk("rst_mid_clk", 32'(clk_o), 32'h0);
    chk("rst_mid_active", 32'(active_o), 32'h0);
    chk("rst_mid_ready", 32'(ready_o), 32'h0);
    rst = 1'b0; locked_i = 1'b0;
    tick();
    startup(e);
    chk("restart_edges", 32'(e), 32'(LW + 3));

    // Random traffic: enables, divider loads (including boundary collisions), lock drops and rare resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) en_i = CH'($urandom);
      if ($urandom_range(9) == 0) begin div_i = DW'($urandom_range(4)); div_load = 1'b1; end
      if (locked_i) begin if ($urandom_range(299) == 0) locked_i = 1'b0; end
      else if ($urandom_range(19) == 0) locked_i = 1'b1;
      rst = ($urandom_range(999) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
